// File: rtl/des_round_engine.sv
`timescale 1ns/1ps
// Purpose: iterative DES block engine, ROUNDS_PER_CYCLE Feistel rounds chained per clock.
// Latency: accept edge to first out_valid cycle = 16/ROUNDS_PER_CYCLE + 1 clocks.
// Backpressure: one block in flight; result held in DONE until out_ready, in_ready low while busy.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   block offer handshake (in_ready high only when idle)
//   in_block[63:0]      plaintext/ciphertext, DES bit 1 = bit 63
//   in_decrypt          0 = encrypt, 1 = decrypt, sampled with in_block
//   sub_keys[767:0]     K_i at [48*i-1 -: 48], i = 1..16, held stable while busy
//   out_valid/out_ready result handshake
//   out_block[63:0]     result block
//   abort               only when DES_ROUND_ENGINE_ABORT_EN is defined: drop the
//                       block in flight and return to idle
// Parameter ROUNDS_PER_CYCLE: legal values 1, 2, 4, 8, 16.
module des_round_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic         in_decrypt,
  input  logic [767:0] sub_keys,
`ifdef DES_ROUND_ENGINE_ABORT_EN
  input  logic         abort,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  // P permutation sources, zero-based from the MSB of the 32-bit S-box output.
  localparam logic [159:0] P_SRC = {
    5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
    5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
    5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
    5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
  };

  // S1..S8 from MSB down; each box is 64 nibbles, row-major (row*16+col),
  // first entry in the top nibble.
  localparam logic [2047:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // IP is regular: rows 0..3 take even source bits 58..64 descending by 8,
  // rows 4..7 take the odd ones 57..63.
  function automatic logic [63:0] ip_perm(input logic [63:0] d);
    logic [63:0] o;
    int          src;
    o = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        src = (r < 4) ? (58 + 2*r - 8*c) : (57 + 2*(r-4) - 8*c);
        o   = {o[62:0], d[6'(64 - src)]};
      end
    end
    return o;
  endfunction

  // FP (IP inverse): even columns walk 40,48,56,64, odd columns 8,16,24,32,
  // every row stepping the base down by one.
  function automatic logic [63:0] fp_perm(input logic [63:0] d);
    logic [63:0] o;
    int          src;
    o = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        src = (c % 2 == 0) ? (40 - r + 4*c) : (8 - r + 4*(c-1));
        o   = {o[62:0], d[6'(64 - src)]};
      end
    end
    return o;
  endfunction

  // E: group g takes source bits 4g..4g+5 (one-based, wrapping 0 -> 32).
  function automatic logic [47:0] expand(input logic [31:0] d);
    logic [47:0] o;
    int          src;
    o = '0;
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 6; j++) begin
        src = ((4*g + j + 31) % 32) + 1;
        o   = {o[46:0], d[5'(32 - src)]};
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] d);
    logic [31:0]  o;
    logic [159:0] t;
    logic [4:0]   sel;
    o = '0;
    t = P_SRC;
    for (int i = 0; i < 32; i++) begin
      sel = t[159:155];
      o   = {o[30:0], d[5'd31 - sel]};
      t   = t << 5;
    end
    return o;
  endfunction

  // Six input bits b1..b6: row = b1b6, column = b2..b5.
  function automatic logic [31:0] sbox_sub(input logic [47:0] x);
    logic [31:0] o;
    logic [47:0] xs;
    logic [5:0]  six;
    logic [5:0]  idx;
    logic [2:0]  bsel;
    o  = '0;
    xs = x;
    for (int b = 0; b < 8; b++) begin
      six  = xs[47:42];
      xs   = xs << 6;
      idx  = {six[5], six[0], six[4:1]};
      bsel = 3'(b);
      o    = {o[27:0], 4'(SBOX >> {3'd7 - bsel, 6'd63 - idx, 2'b00})};
    end
    return o;
  endfunction

  function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
    return p_perm(sbox_sub(expand(r) ^ k));
  endfunction

  state_t      state_q;
  logic [31:0] l_q, r_q;
  logic [3:0]  cnt_q;
  logic        mode_q;

  logic [31:0] l_nxt, r_nxt;
  logic [63:0] ip_in;
  logic [63:0] fp_out;
  logic        round_last;

  // Round chain for one clock. Round number is cnt_q + j + 1; the zero-based
  // key index is that minus one when encrypting and 16 minus it when
  // decrypting, which in 4 bits is simply the bitwise inverse.
  always_comb begin
    logic [31:0] l_t, r_t, tmp;
    logic [3:0]  rnd, kidx;
    logic [47:0] k;
    l_t  = l_q;
    r_t  = r_q;
    tmp  = '0;
    rnd  = '0;
    kidx = '0;
    k    = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      rnd  = cnt_q + 4'(j);
      kidx = mode_q ? ~rnd : rnd;
      k    = 48'(sub_keys >> (kidx * 10'd48));
      tmp  = l_t ^ f_func(r_t, k);
      l_t  = r_t;
      r_t  = tmp;
    end
    l_nxt = l_t;
    r_nxt = r_t;
  end

  assign ip_in  = ip_perm(in_block);
  // Final swap: output is FP(R16 || L16).
  assign fp_out = fp_perm({r_nxt, l_nxt});
  // The 4-bit counter wraps to 0 on exactly the step that completes round 16.
  assign round_last = (cnt_q == 4'(16 - ROUNDS_PER_CYCLE));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_block <= '0;
      l_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            l_q      <= ip_in[63:32];
            r_q      <= ip_in[31:0];
            mode_q   <= in_decrypt;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= ROUND;
          end
        end
        ROUND: begin
`ifdef DES_ROUND_ENGINE_ABORT_EN
          if (abort) begin
            state_q  <= IDLE;
            in_ready <= 1'b1;
          end else
`endif
          begin
            l_q   <= l_nxt;
            r_q   <= r_nxt;
            cnt_q <= cnt_q + 4'(ROUNDS_PER_CYCLE);
            if (round_last) begin
              out_block <= fp_out;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end
          end
        end
        DONE: begin
`ifdef DES_ROUND_ENGINE_ABORT_EN
          if (abort) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else
`endif
          // in_ready rises only after this edge, so nothing is accepted on
          // the output handshake edge itself.
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/des_round_engine.md
DES_ROUND_ENGINE -- requirements
Module: des_round_engine

Interface
REQ-001 Parameter ROUNDS_PER_CYCLE, default 1: Feistel rounds evaluated per clock; legal values 1, 2, 4, 8, 16.
REQ-002 Clk  input  1  clock; every register SHALL update on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  block/mode offer valid.
REQ-005 in_ready  output  1  engine can accept a block.
REQ-006 in_block  input  64  plaintext or ciphertext, DES bit 1 = bit 63.
REQ-007 in_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with in_block.
REQ-008 sub_keys  input  768  K_i at [48*i-1 : 48*(i-1)], i = 1..16; source SHALL hold it stable from accept until output handshake.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  sink accepts result.
REQ-011 out_block  output  64  result block.

Function
REQ-012 States SHALL be IDLE, ROUND, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-013 Accept when in_valid & in_ready: latch IP(in_block) into L (upper 32) / R (lower 32), latch in_decrypt, round counter = 0, go to ROUND.
REQ-014 F(R, K) SHALL be P(SBOX(E(R) xor K)): 32->48 expansion, 48-bit xor, eight S-boxes 48->32, 32-bit P permutation, all per FIPS 46-3.
REQ-015 Each round n (1..16): L_n = R_{n-1}; R_n = L_{n-1} xor F(R_{n-1}, K); K = K_n when encrypting, K_{17-n} when decrypting.
REQ-016 ROUND SHALL chain ROUNDS_PER_CYCLE rounds combinationally per cycle and advance the 4-bit round counter by ROUNDS_PER_CYCLE.
REQ-017 After round 16, out_block register = FP(R16 || L16), go to DONE; ROUND occupancy = 16/ROUNDS_PER_CYCLE cycles.
REQ-018 Latency: accept edge to first out_valid cycle = 16/ROUNDS_PER_CYCLE + 1 clocks (17 for default).
REQ-019 DONE SHALL hold out_valid and out_block stable until out_ready = 1; that edge returns to IDLE.
REQ-020 No overlap: a new block SHALL NOT be accepted on the output-handshake edge; in_ready rises the following cycle.
REQ-021 in_valid while busy SHALL be ignored with no state change; in_block/in_decrypt changes after accept SHALL have no effect.
REQ-022 Round counter wrap from 16 to 0 SHALL coincide only with the ROUND->DONE transition.

Reset
REQ-023 Reset SHALL override all other inputs, including mid-ROUND and mid-DONE, and abandon any block in flight.
REQ-024 Reset values: state IDLE, in_ready 1, out_valid 0, out_block 0, L/R 0, counter 0, latched mode 0.

Configuration
REQ-025 Macro DES_ROUND_ENGINE_ABORT_EN: when defined, adds input abort (1 bit) -- abort = 1 in ROUND or DONE returns to IDLE next edge, out_valid 0, out_block unchanged, no output produced; ignored in IDLE and lower priority than Reset.
REQ-026 Without DES_ROUND_ENGINE_ABORT_EN: no abort port; a block, once accepted, always completes.

Verification
REQ-027 Encrypt, key 133457799BBCDFF1 (bench-derived K1..K16), in_block 0123456789ABCDEF -> out_block 85E813540F0AB405, out_valid on cycle 17 after accept (ROUNDS_PER_CYCLE = 1).
REQ-028 Decrypt with same keys, in_block 85E813540F0AB405 -> out_block 0123456789ABCDEF; repeat with ROUNDS_PER_CYCLE = 4 -> out_valid on cycle 5.
REQ-029 Backpressure: out_ready held 0 for 10 cycles in DONE -> out_valid and out_block stable throughout; in_ready 0; in_valid pulses ignored.
REQ-030 Reset asserted at round 8 -> next cycle in_ready 1, out_valid 0, out_block 0; subsequent block completes correctly.
REQ-031 Back-to-back: in_valid held 1 with two blocks -> second accepted one cycle after first output handshake; both results match the golden model.
REQ-032 With DES_ROUND_ENGINE_ABORT_EN, abort at round 5 -> IDLE next cycle, no out_valid pulse; without the macro, same stimulus completes normally.
